// File: rtl/isa_pkg.sv
// Shared fetch/ISA definitions: datapath widths, fetch FSM states, control opcodes.
package isa_pkg;

    localparam int unsigned PC_W    = 10;
    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OFF_W   = 8;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    // Control-flow opcodes live at the top of the opcode space
    typedef enum logic [INSTR_W-1:0] {
        OP_BRF  = 8'hF1,
        OP_BRB  = 8'hF2,
        OP_HALT = 8'hFF
    } ctrl_op_e;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_cycle_counter.sv
// Saturating count of active fetch cycles (RUN/FLUSH); present only when
// FETCH_CYCLE_COUNT_EN is defined.
`ifdef FETCH_CYCLE_COUNT_EN
module fetch_cycle_counter
    import isa_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential ROM addressing with one-bubble taken branches and halt.
// FETCH_CYCLE_COUNT_EN adds the cycle_count_o port and counter.
module fetch_unit
    import isa_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    input  logic [PC_W-1:0]    start_addr_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [INSTR_W-1:0] instruction_o,
    output logic               instr_valid_o,
    output logic [PC_W-1:0]    instr_pc_o,
    input  logic               branchf_i,
    input  logic               branchb_i,
    input  logic [OFF_W-1:0]   branch_offset_i,
    input  logic               done_i,
    output logic               done_o
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0]   cycle_count_o
`endif
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] imem_addr_q, imem_addr_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            done_q, done_d;

    logic            start_ok;
    logic            take_done;
    logic            take_br;
    logic [PC_W-1:0] br_target;

    // Decoder qualifiers only count against a live instruction; done beats branches
    assign start_ok  = start_i && ((state_q == ST_IDLE) || (state_q == ST_HALT));
    assign take_done = (state_q == ST_RUN) && instr_valid_q && done_i;
    assign take_br   = (state_q == ST_RUN) && instr_valid_q && !done_i && (branchf_i || branchb_i);
    assign br_target = branchf_i ? (instr_pc_q + PC_W'(branch_offset_i))
                                 : (instr_pc_q - PC_W'(branch_offset_i));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT: if (start_ok) state_d = ST_RUN;
            ST_RUN: begin
                if (take_done) begin
                    state_d = ST_HALT;
                end else if (take_br) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FLUSH fetches target+1 while the target's data returns from the ROM
    always_comb begin
        imem_addr_d   = imem_addr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = 1'b0;
        done_d        = done_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start_ok) begin
                    imem_addr_d = start_addr_i;
                    done_d      = 1'b0;
                end
            end
            ST_RUN: begin
                if (take_done) begin
                    done_d = 1'b1;
                end else if (take_br) begin
                    imem_addr_d = br_target;
                end else begin
                    imem_addr_d   = pc_inc(imem_addr_q);
                    instr_pc_d    = imem_addr_q;
                    instr_valid_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                imem_addr_d   = pc_inc(imem_addr_q);
                instr_pc_d    = imem_addr_q;
                instr_valid_d = 1'b1;
            end
            default: begin
                imem_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            imem_addr_q   <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            imem_addr_q   <= imem_addr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            done_q        <= done_d;
        end
    end

    // ROM data arrives one cycle after its address, aligned with instr_pc_q
    assign instruction_o = instr_valid_q ? imem_data_i : '0;
    assign imem_addr_o   = imem_addr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = instr_valid_q;
    assign done_o        = done_q;

`ifdef FETCH_CYCLE_COUNT_EN
    logic cnt_inc;
    assign cnt_inc = (state_q == ST_RUN) || (state_q == ST_FLUSH);

    fetch_cycle_counter u_cycle_counter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (start_ok),
        .inc_i     (cnt_inc),
        .count_o   (cycle_count_o)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: branch/halt vector table, scoreboard of
// expected fetched PCs, and hand sequences for ignore rules, reset-in-flush and the counter.
module tb_fetch_unit;
    import isa_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [9:0]  start_addr_i = '0;
    logic [9:0]  imem_addr_o;
    logic [7:0]  imem_data_i = '0;
    logic [7:0]  instruction_o;
    logic        instr_valid_o;
    logic [9:0]  instr_pc_o;
    logic        branchf_i = 1'b0;
    logic        branchb_i = 1'b0;
    logic [7:0]  branch_offset_i = '0;
    logic        done_i = 1'b0;
    logic        done_o;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cycle_count_o;
`endif

    fetch_unit dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .start_i         (start_i),
        .start_addr_i    (start_addr_i),
        .imem_addr_o     (imem_addr_o),
        .imem_data_i     (imem_data_i),
        .instruction_o   (instruction_o),
        .instr_valid_o   (instr_valid_o),
        .instr_pc_o      (instr_pc_o),
        .branchf_i       (branchf_i),
        .branchb_i       (branchb_i),
        .branch_offset_i (branch_offset_i),
        .done_i          (done_i),
        .done_o          (done_o)
`ifdef FETCH_CYCLE_COUNT_EN
        ,
        .cycle_count_o   (cycle_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Synchronous ROM model
    logic [7:0] rom [1024];
    always @(posedge clk_i) imem_data_i <= rom[imem_addr_o];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected instr_pc_o sequence, popped on every valid instruction
    logic [9:0] sb_q[$];
    bit         mon_en = 1'b0;

    always @(posedge clk_i) begin
        logic [9:0] exp_pc;
        #3;
        if (mon_en) begin
            if (instr_valid_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got valid pc %0h expected no instruction", instr_pc_o);
                end else begin
                    exp_pc = sb_q.pop_front();
                    chk("sb_pc", 32'(instr_pc_o), 32'(exp_pc));
                    chk("sb_instr", 32'(instruction_o), 32'(rom[exp_pc]));
                end
            end else begin
                chk("sb_bubble_instr", 32'(instruction_o), 32'h0);
            end
        end
    end

    typedef struct {
        logic [9:0] start;
        logic [9:0] at_pc;
        logic [1:0] kind;   // 0 brf, 1 brb, 2 done+brf, 3 brf+brb
        logic [7:0] off;
        logic [9:0] target;
    } vec_t;

    vec_t vecs[6];

    task automatic do_reset();
        mon_en = 1'b0;
        sb_q.delete();
        @(negedge clk_i);
        reset_n_i = 1'b0;
        start_i = 1'b0; branchf_i = 1'b0; branchb_i = 1'b0; done_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    task automatic wait_pc(input logic [9:0] pc);
        int n;
        for (n = 0; n < 64 && !(instr_valid_o && instr_pc_o == pc); n++) @(negedge clk_i);
        if (n == 64) begin
            checks++;
            errors++;
            $display("FAIL wait_pc: got no valid pc %0h expected within 64 cycles", pc);
        end
    endtask

    task automatic check_sb_empty(input string name);
        chk(name, 32'(sb_q.size()), 32'h0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [9:0] p;
        logic [9:0] e;
        int n;
        do_reset();
        p = v.start;
        for (n = 0; n < 64; n++) begin
            sb_q.push_back(p);
            if (p == v.at_pc) break;
            p = p + 10'd1;
        end
        if (v.kind != 2'd2) begin
            sb_q.push_back(v.target);
            sb_q.push_back(v.target + 10'd1);
        end
        mon_en = 1'b1;
        start_i = 1'b1;
        start_addr_i = v.start;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("start_addr", 32'(imem_addr_o), 32'(v.start));
        chk("first_run_valid", 32'(instr_valid_o), 32'h0);
        @(negedge clk_i);
        e = v.start + 10'd1;
        chk("second_addr", 32'(imem_addr_o), 32'(e));
        wait_pc(v.at_pc);
        branch_offset_i = v.off;
        branchf_i = (v.kind != 2'd1);
        branchb_i = (v.kind == 2'd1) || (v.kind == 2'd3);
        done_i    = (v.kind == 2'd2);
        @(negedge clk_i);
        branchf_i = 1'b0; branchb_i = 1'b0; done_i = 1'b0;
        if (v.kind == 2'd2) begin
            e = v.at_pc + 10'd1;
            for (int k = 0; k < 3; k++) begin
                chk("halt_done", 32'(done_o), 32'h1);
                chk("halt_addr_frozen", 32'(imem_addr_o), 32'(e));
                chk("halt_valid", 32'(instr_valid_o), 32'h0);
                @(negedge clk_i);
            end
        end else begin
            chk("flush_valid", 32'(instr_valid_o), 32'h0);
            chk("flush_addr", 32'(imem_addr_o), 32'(v.target));
            for (n = 0; n < 8 && sb_q.size() != 0; n++) @(negedge clk_i);
        end
        check_sb_empty("sb_drained");
        mon_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 8'(i * 37 + 11);
        rom[10'h020] = OP_BRF;
        rom[10'h003] = OP_BRB;
        rom[10'h040] = OP_HALT;

        vecs[0] = '{10'h010, 10'h020, 2'd0, 8'h05, 10'h025};
        vecs[1] = '{10'h3FC, 10'h003, 2'd1, 8'h05, 10'h3FE};
        vecs[2] = '{10'h100, 10'h104, 2'd3, 8'h10, 10'h114};
        vecs[3] = '{10'h3F0, 10'h3F8, 2'd0, 8'hFF, 10'h0F7};
        vecs[4] = '{10'h200, 10'h200, 2'd1, 8'h00, 10'h200};
        vecs[5] = '{10'h030, 10'h040, 2'd2, 8'h05, 10'h000};

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_addr", 32'(imem_addr_o), 32'h0);
        chk("rst_pc", 32'(instr_pc_o), 32'h0);
        chk("rst_valid", 32'(instr_valid_o), 32'h0);
        chk("rst_instr", 32'(instruction_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        reset_n_i = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Restart from HALT without reset
        sb_q.push_back(10'h000);
        sb_q.push_back(10'h001);
        mon_en = 1'b1;
        start_i = 1'b1;
        start_addr_i = 10'h000;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("restart_done_clr", 32'(done_o), 32'h0);
        chk("restart_addr", 32'(imem_addr_o), 32'h0);
        @(negedge clk_i);
        chk("restart_addr1", 32'(imem_addr_o), 32'h1);
        @(negedge clk_i);
        check_sb_empty("restart_sb");
        mon_en = 1'b0;

        // start_i in RUN and decoder inputs without a live instruction are ignored
        do_reset();
        sb_q.push_back(10'h100);
        sb_q.push_back(10'h101);
        mon_en = 1'b1;
        start_i = 1'b1;
        start_addr_i = 10'h100;
        @(negedge clk_i);
        start_addr_i = 10'h2A0;
        branchf_i = 1'b1;
        done_i = 1'b1;
        branch_offset_i = 8'h40;
        @(negedge clk_i);
        branchf_i = 1'b0;
        done_i = 1'b0;
        chk("ign_addr", 32'(imem_addr_o), 32'h101);
        chk("ign_done", 32'(done_o), 32'h0);
        @(negedge clk_i);
        start_i = 1'b0;
        chk("ign_start_run", 32'(imem_addr_o), 32'h102);
        check_sb_empty("ign_sb");
        mon_en = 1'b0;

        // Reset asserted during FLUSH
        do_reset();
        sb_q.push_back(10'h020);
        sb_q.push_back(10'h021);
        sb_q.push_back(10'h022);
        mon_en = 1'b1;
        start_i = 1'b1;
        start_addr_i = 10'h020;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_pc(10'h022);
        branchf_i = 1'b1;
        branch_offset_i = 8'h03;
        @(negedge clk_i);
        branchf_i = 1'b0;
        chk("rf_in_flush", 32'(instr_valid_o), 32'h0);
        reset_n_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        chk("rf_addr", 32'(imem_addr_o), 32'h0);
        chk("rf_pc", 32'(instr_pc_o), 32'h0);
        chk("rf_valid", 32'(instr_valid_o), 32'h0);
        chk("rf_done", 32'(done_o), 32'h0);
        @(negedge clk_i);
        chk("rf_idle_addr", 32'(imem_addr_o), 32'h0);
        chk("rf_idle_valid", 32'(instr_valid_o), 32'h0);
        check_sb_empty("rf_sb");
        mon_en = 1'b0;

`ifdef FETCH_CYCLE_COUNT_EN
        // Cycle counter: start at 0, halt at pc 004
        do_reset();
        chk("cnt_reset", 32'(cycle_count_o), 32'h0);
        for (int i = 0; i < 5; i++) sb_q.push_back(10'(i));
        mon_en = 1'b1;
        start_i = 1'b1;
        start_addr_i = 10'h000;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_pc(10'h004);
        done_i = 1'b1;
        @(negedge clk_i);
        done_i = 1'b0;
        chk("cnt_halt_done", 32'(done_o), 32'h1);
        chk("cnt_at_halt", 32'(cycle_count_o), 32'd6);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("cnt_frozen", 32'(cycle_count_o), 32'd6);
        mon_en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion before 200000");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset_n_i  in  1  synchronous, active-low reset, sampled on clk_i rising edge.
REQ-003 SHALL have ports: start_i  in  1  begin execution at start_addr_i; honoured only in IDLE or HALT.
REQ-004 SHALL have ports: start_addr_i  in  10  first instruction address.
REQ-005 SHALL have ports: imem_addr_o  out  10  instruction ROM address, registered.
REQ-006 SHALL have ports: imem_data_i  in  8  ROM data, valid one cycle after imem_addr_o.
REQ-007 SHALL have ports: instruction_o  out  8  instruction to decoder; 8'h00 whenever instr_valid_o=0.
REQ-008 SHALL have ports: instr_valid_o  out  1  instruction_o is live; decoder outputs are qualified by it.
REQ-009 SHALL have ports: instr_pc_o  out  10  address of the instruction on instruction_o.
REQ-010 SHALL have ports: branchf_i / branchb_i  in  1 each  taken forward/backward branch from decoder, same cycle as instruction_o.
REQ-011 SHALL have ports: branch_offset_i  in  8  unsigned branch distance (rs register value).
REQ-012 SHALL have ports: done_i  in  1  halt decoded, same cycle as instruction_o.
REQ-013 SHALL have ports: done_o  out  1  program halted.

Function
REQ-014 SHALL implement states IDLE, RUN, FLUSH, HALT.
REQ-015 IDLE: start_i=1 -> imem_addr_o<=start_addr_i, go RUN; instr_valid_o=0.
REQ-016 RUN: each cycle imem_addr_o<=imem_addr_o+1 (mod 1024); instr_valid_o=1 from the second RUN cycle on, instr_pc_o = previous imem_addr_o.
REQ-017 branchf_i with instr_valid_o=1 -> imem_addr_o<=instr_pc_o+branch_offset_i (mod 1024), go FLUSH.
REQ-018 branchb_i with instr_valid_o=1 -> imem_addr_o<=instr_pc_o-branch_offset_i (mod 1024), go FLUSH.
REQ-019 FLUSH: exactly one cycle, instr_valid_o=0 (wrong-path data discarded), imem_addr_o<=target+1, return RUN; target instruction valid in the following cycle.
REQ-020 Taken-branch penalty SHALL be exactly one bubble cycle.
REQ-021 done_i with instr_valid_o=1 -> go HALT; done_o=1 from next cycle, instr_valid_o=0, imem_addr_o frozen.
REQ-022 HALT: done_o held until reset or start_i; start_i -> done_o<=0, restart as REQ-015.
REQ-023 Priority: done_i over branches; branchf_i over branchb_i (both high is illegal, forward taken).
REQ-024 branchf_i, branchb_i, done_i SHALL be ignored when instr_valid_o=0; start_i ignored in RUN/FLUSH.
REQ-025 Address wrap: 10'h3FF+1 -> 10'h000, no flag.

Reset
REQ-026 reset_n_i=0 -> state IDLE, imem_addr_o=0, instr_pc_o=0, instr_valid_o=0, instruction_o=0, done_o=0; overrides any in-progress fetch, branch or halt in the same cycle.

Configuration
REQ-027 Macro FETCH_CYCLE_COUNT_EN defined -> extra output cycle_count_o[15:0]: cleared on reset and on accepted start_i, +1 each RUN/FLUSH cycle, saturates at 16'hFFFF, frozen in HALT; undefined -> port and counter absent, all other behaviour identical.

Structure
REQ-028 Shared package isa_pkg SHALL hold PC width (10), instruction width (8), fetch state enum, halt/branch opcode constants.
REQ-029 Sub-module fetch_cycle_counter SHALL implement REQ-027, instantiated only under FETCH_CYCLE_COUNT_EN.

Verification
REQ-030 Reset, start_i with start_addr_i=10'h010 -> imem_addr_o 010,011,012; instr_valid_o first high with instr_pc_o=010.
REQ-031 branchf_i at instr_pc_o=020, offset=8'h05 -> one bubble, next valid instr_pc_o=025, then 026.
REQ-032 branchb_i at instr_pc_o=003, offset=8'h05 -> next valid instr_pc_o=3FE (wrap).
REQ-033 done_i and branchf_i together at pc 040 -> HALT, done_o=1, imem_addr_o frozen at 041; start_i with start_addr_i=0 -> done_o=0, restart at 000.
REQ-034 reset_n_i low during FLUSH -> next cycle all outputs at reset values, state IDLE.
REQ-035 With FETCH_CYCLE_COUNT_EN, start at 0, halt at pc 004 with no branches -> cycle_count_o=6, frozen in HALT.
